// File: rtl/iir_channel_scheduler_if.sv
// Sample/result stream bundle for iir_channel_scheduler.
// master: sample sources and result consumer; slave: the scheduler.
interface iir_channel_scheduler_if;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [15:0] x_in;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ch;
  logic [7:0]  y_out;

  modport master (
    output in_valid, x_in, out_ready,
    input  in_ready, out_valid, out_ch, y_out
  );

  modport slave (
    input  in_valid, x_in, out_ready,
    output in_ready, out_valid, out_ch, y_out
  );
endinterface

// File: rtl/iir_channel_scheduler.sv
// iir_channel_scheduler: one first-order IIR datapath shared by four channels.
// Round-robin grant in IDLE, one filter update in CALC, result held in OUT.
// Optional macro IIR_SCHED_SAT_EN: results saturate to [-128,127] instead of
// wrapping to the low 8 bits.
module iir_channel_scheduler (
  input  logic                          clk,
  input  logic                          reset_n,
  iir_channel_scheduler_if.slave        bus,
  input  logic [3:0]                    sleep_i,
  input  logic                          cfg_we_i,
  input  logic                          cfg_clr_i,
  input  logic [1:0]                    cfg_ch_i,
  input  logic [3:0]                    cfg_b0_i,
  input  logic [3:0]                    cfg_b1_i,
  input  logic [3:0]                    cfg_a1_i,
  output logic                          busy_o
);

  localparam int unsigned NCH = 4;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_OUT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  rr_ptr_q;

  // per-channel context
  logic [3:0]  ctx_b0_q [NCH];
  logic [3:0]  ctx_b1_q [NCH];
  logic [3:0]  ctx_a1_q [NCH];
  logic [3:0]  ctx_xp_q [NCH];
  logic [7:0]  ctx_yp_q [NCH];

  // operands latched at grant
  logic [1:0]  g_q;
  logic [3:0]  x_q, b0_q, b1_q, a1_q, xp_q;
  logic [7:0]  yp_q;

  // result registers
  logic        out_valid_q;
  logic [1:0]  out_ch_q;
  logic [7:0]  y_out_q;

  // arbiter
  logic [3:0]  req;
  logic        grant_any;
  logic [1:0]  grant_ch;
  logic [1:0]  idx;
  logic [3:0]  grant_oh;
  logic [3:0]  x_sel;

  // datapath
  logic signed [7:0]  b0e, b1e, xe, xpe, p0, p1;
  logic signed [11:0] a1e, ype, p2, sh;
  logic signed [12:0] s;
  logic [7:0]         y_fmt;

  // Round-robin search: first requester strictly after rr_ptr, wrapping.
  always_comb begin
    req       = bus.in_valid & ~sleep_i;
    grant_any = 1'b0;
    grant_ch  = '0;
    idx       = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (!grant_any && req[idx]) begin
        grant_any = 1'b1;
        grant_ch  = idx;
      end
    end
    x_sel = bus.x_in[{grant_ch, 2'b00} +: 4];
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state and combinational grant strobe
  always_comb begin
    state_d  = state_q;
    grant_oh = '0;
    unique case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          grant_oh[grant_ch] = 1'b1;
          state_d            = S_CALC;
        end
      end
      S_CALC:  state_d = S_OUT;
      S_OUT:   if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Filter arithmetic on latched operands: b0*x + b1*xp + floor(a1*yp/8)
  always_comb begin
    xe  = {{4{x_q[3]}},  x_q};
    b0e = {{4{b0_q[3]}}, b0_q};
    b1e = {{4{b1_q[3]}}, b1_q};
    xpe = {{4{xp_q[3]}}, xp_q};
    a1e = {{8{a1_q[3]}}, a1_q};
    ype = {{4{yp_q[7]}}, yp_q};
    p0  = b0e * xe;
    p1  = b1e * xpe;
    p2  = a1e * ype;
    sh  = p2 >>> 3;
    s   = {{5{p0[7]}}, p0} + {{5{p1[7]}}, p1} + {sh[11], sh};
`ifdef IIR_SCHED_SAT_EN
    if (s > 13'sd127)       y_fmt = 8'h7F;
    else if (s < -13'sd128) y_fmt = 8'h80;
    else                    y_fmt = s[7:0];
`else
    y_fmt = s[7:0];
`endif
  end

  // Grant latch, round-robin pointer and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q    <= 2'd3;
      g_q         <= '0;
      x_q         <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      a1_q        <= '0;
      xp_q        <= '0;
      yp_q        <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      y_out_q     <= '0;
    end else begin
      if (state_q == S_IDLE && grant_any) begin
        rr_ptr_q <= grant_ch;
        g_q      <= grant_ch;
        x_q      <= x_sel;
        b0_q     <= ctx_b0_q[grant_ch];
        b1_q     <= ctx_b1_q[grant_ch];
        a1_q     <= ctx_a1_q[grant_ch];
        xp_q     <= ctx_xp_q[grant_ch];
        yp_q     <= ctx_yp_q[grant_ch];
      end
      if (state_q == S_CALC) begin
        y_out_q     <= y_fmt;
        out_ch_q    <= g_q;
        out_valid_q <= 1'b1;
      end else if (state_q == S_OUT && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Context store: coefficient writes, CALC writeback, clear (clear has last word)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        ctx_b0_q[i] <= '0;
        ctx_b1_q[i] <= '0;
        ctx_a1_q[i] <= '0;
        ctx_xp_q[i] <= '0;
        ctx_yp_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (cfg_we_i && cfg_ch_i == 2'(i)) begin
          ctx_b0_q[i] <= cfg_b0_i;
          ctx_b1_q[i] <= cfg_b1_i;
          ctx_a1_q[i] <= cfg_a1_i;
        end
        if (state_q == S_CALC && g_q == 2'(i)) begin
          ctx_xp_q[i] <= x_q;
          ctx_yp_q[i] <= y_fmt;
        end
        if (cfg_clr_i && cfg_ch_i == 2'(i)) begin
          ctx_xp_q[i] <= '0;
          ctx_yp_q[i] <= '0;
        end
      end
    end
  end

  assign bus.in_ready  = grant_oh;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.y_out     = y_out_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule
